param_lifo_stack: RTL and testbench

- Parametrised synchronous LIFO stack. Generalises the fixed 8x8 stack to configurable data width and depth.
- Usable capacity is the full DEPTH entries; full is asserted only when all DEPTH entries hold data.
- Adds simultaneous push+pop (replace top), synchronous clear, occupancy count, almost-full flag and overflow/underflow error pulses.
- Used as a return-address or operand stack for datapath blocks in the same design.

---
 rtl/param_lifo_stack.sv | 76 +++++++
 tb/tb_param_lifo_stack.sv | 100 ++++++++++
 2 files changed

// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised LIFO with replace-top, sync clear, occupancy and error pulses
module param_lifo_stack #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, we;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    we      = 1'b0;
    // replace writes over the current top; a plain push writes one above it
    wr_idx  = (pop && count_q != '0) ? IDX_W'(count_q - CNT_W'(1)) : IDX_W'(count_q);
    rd_idx  = (count_q > CNT_W'(1)) ? IDX_W'(count_q - CNT_W'(2)) : '0;
    if (clr) begin
      count_d = '0;
      dout_d  = '0;
    end else if (push && (pop || count_q != CNT_W'(DEPTH))) begin
      we      = 1'b1;
      dout_d  = din;
      count_d = (pop && count_q != '0) ? count_q : count_q + CNT_W'(1);
    end else if (push) begin
      ovf_d = 1'b1;
    end else if (pop && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
      dout_d  = (count_q > CNT_W'(1)) ? mem[rd_idx] : '0;
    end else if (pop) begin
      unf_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= din;
  end
  assign dout        = dout_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign empty       = count_q == '0;
  assign full        = count_q == CNT_W'(DEPTH);
  assign almost_full = count_q >= CNT_W'(AFULL_LVL);
endmodule

// File: tb/tb_param_lifo_stack.sv
// tb_param_lifo_stack: directed vectors with a queue scoreboard checked by a separate monitor
module tb_param_lifo_stack;
  logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] din = '0, dout;
  logic [3:0] count;
  logic       empty, full, almost_full, overflow, underflow;
  int         n_vec = 0, n_bad = 0, due = 0;
  typedef struct {
    string      nm;
    logic [3:0] c;
    logic [7:0] d;
    logic       o;
    logic       u;
  } exp_t;
  exp_t q[$];
  param_lifo_stack #(.DATA_W(8), .DEPTH(8), .AFULL_LVL(7)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
    .dout(dout), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic compare(input exp_t e);
    logic ee, ef, ea;
    ee = e.c == 4'd0;
    ef = e.c == 4'd8;
    ea = e.c >= 4'd7;
    n_vec++;
    if (count !== e.c || dout !== e.d || empty !== ee || full !== ef || almost_full !== ea ||
        overflow !== e.o || underflow !== e.u) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d dout=%h e/f/af=%b%b%b ovf=%b unf=%b, expected cnt=%0d dout=%h e/f/af=%b%b%b ovf=%b unf=%b",
               e.nm, count, dout, empty, full, almost_full, overflow, underflow,
               e.c, e.d, ee, ef, ea, e.o, e.u);
    end
  endtask
  always @(posedge clk) due = q.size();
  always @(negedge clk) if (due > 0) compare(q.pop_front());
  task automatic op(input logic p, input logic po, input logic c, input logic [7:0] d,
                    input logic [3:0] ec, input logic [7:0] ed, input logic eo, input logic eu,
                    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    push = p; pop = po; clr = c; din = d;
    e.nm = nm; e.c = ec; e.d = ed; e.o = eo; e.u = eu;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, "reset_state");
    for (int i = 0; i < 8; i++)
      op(1, 0, 0, 8'(8'h11 * (i + 1)), 4'(i + 1), 8'(8'h11 * (i + 1)), 0, 0, "push_fill");
    op(1, 0, 0, 8'h99, 8, 8'h88, 1, 0, "push_overflow");
    op(0, 0, 0, 8'h00, 8, 8'h88, 0, 0, "overflow_one_cycle");
    for (int i = 0; i < 8; i++)
      op(0, 1, 0, 8'h00, 4'(7 - i), 8'(8'h11 * (7 - i)), 0, 0, "pop_drain");
    op(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "pop_underflow");
    op(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, "underflow_one_cycle");
    op(1, 0, 0, 8'hA1, 1, 8'hA1, 0, 0, "push_a1");
    op(1, 0, 0, 8'hA2, 2, 8'hA2, 0, 0, "push_a2");
    op(1, 1, 0, 8'hB3, 2, 8'hB3, 0, 0, "replace_b3");
    op(0, 1, 0, 8'h00, 1, 8'hA1, 0, 0, "pop_after_replace");
    for (int i = 0; i < 7; i++)
      op(1, 0, 0, 8'(8'hC1 + i), 4'(i + 2), 8'(8'hC1 + i), 0, 0, "refill");
    op(1, 1, 0, 8'hD5, 8, 8'hD5, 0, 0, "replace_full");
    op(0, 1, 0, 8'h00, 7, 8'hC6, 0, 0, "pop_below_replace");
    op(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, "clr_to_empty");
    op(1, 1, 0, 8'h5C, 1, 8'h5C, 0, 0, "pushpop_empty");
    op(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, "clr_again");
    for (int i = 0; i < 3; i++)
      op(1, 0, 0, 8'(8'h31 + i), 4'(i + 1), 8'(8'h31 + i), 0, 0, "push3");
    op(1, 0, 1, 8'hEE, 0, 8'h00, 0, 0, "clr_with_push");
    op(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, "clr_with_pop");
    for (int i = 0; i < 4; i++)
      op(1, 0, 0, 8'(8'h41 + i), 4'(i + 1), 8'(8'h41 + i), 0, 0, "push4");
    @(posedge clk);
    #1 push = 1'b1; pop = 1'b0; clr = 1'b0; din = 8'h45;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e.nm = "async_reset"; e.c = 0; e.d = 8'h00; e.o = 0; e.u = 0;
    compare(e);
    push = 1'b0;
    @(posedge clk);
    #1 e.nm = "reset_held"; compare(e);
    @(negedge clk) rst = 1'b0;
    op(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "underflow_after_reset");
    op(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, "final_idle");
    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
